regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the single-bus general-purpose register bank. Provides NUM_REGS registers of WIDTH bits with two combinational read ports and one write-back port. A per-register pending scoreboard tracks registers awaiting write-back from multi-cycle units such as mul/div and memory loads. It also supports optional write-to-read bypass and Mini SRC base-address zeroing on R0.

Parameters:
WIDTH, 32, data width of every register
NUM_REGS, 16, number of registers (2..64, need not be a power of two)
ADDR_W, $clog2(NUM_REGS), register address width
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports
R0_ZERO, 1, 1 = port A returns 0 for R0 when ba_sel_a is high

Ports:
Clock  input  1  system clock, rising edge
Clear  input  1  asynchronous active-high reset
rd_addr_a  input  ADDR_W  read port A address
ba_sel_a  input  1  base-address select; R0 reads as zero on port A (when R0_ZERO=1)
rd_data_a  output  WIDTH  port A data
rd_ready_a  output  1  port A data valid (register not pending, or bypassed)
rd_addr_b  input  ADDR_W  read port B address
rd_data_b  output  WIDTH  port B data
rd_ready_b  output  1  port B data valid
iss_valid  input  1  request to mark iss_rd pending
iss_rd  input  ADDR_W  destination register being issued
iss_ready  output  1  issue accepted this cycle when iss_valid high
wb_valid  input  1  write-back strobe
wb_addr  input  ADDR_W  write-back destination
wb_data  input  WIDTH  write-back data
pending  output  NUM_REGS  scoreboard vector, bit i = register i pending
wb_err  output  1  sticky: write-back to a non-pending or out-of-range register

Behaviour:
- Reset: Clear high asynchronously forces all registers to 0, pending to 0 and wb_err to 0. Clear asserted mid-operation discards all outstanding pending state. No state changes while Clear is high.
- Write: on rising Clock with wb_valid and wb_addr < NUM_REGS, reg[wb_addr] <= wb_data and pending[wb_addr] <= 0. Written data is visible through the register array on the next cycle.
- Read (combinational, zero latency), evaluated for each port in priority order:
  - Port A only: R0_ZERO && ba_sel_a && rd_addr_a==0 -> data 0, ready 1. Applies regardless of R0 contents or pending state.
  - addr >= NUM_REGS -> data 0, ready 1.
  - BYPASS && wb_valid && wb_addr==addr -> data wb_data, ready 1.
  - Otherwise -> data reg[addr], ready !pending[addr].
- Issue:
  - iss_ready = (iss_rd < NUM_REGS) && (!pending[iss_rd] || (wb_valid && wb_addr==iss_rd)).
  - Accepted issue (iss_valid && iss_ready) sets pending[iss_rd] on the next rising edge.
  - Only one write is ever outstanding per register; a WAW issue to a pending register stalls, with iss_ready low.
- Simultaneous issue and write-back to the same register in one cycle: the data is written and the issue's set takes priority over the write-back's clear, so pending ends at 1.
- Error: wb_valid to a register whose pending bit is 0 still performs the write and sets wb_err. wb_valid with wb_addr >= NUM_REGS performs no write and sets wb_err. wb_err clears only on Clear.
- The pending output is a direct register output, with no combinational path from the inputs.
- R0 is a normal storage register; zeroing happens only on port A under ba_sel_a.

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH and NUM_REGS constants
  - the ADDR_W derivation function
  - the R0 index constant
- Natural sub-module: regfile_sb_port. It is the combinational read-port slice (zeroing, range check, bypass mux, ready), instantiated twice with ZERO_EN tied to R0_ZERO on port A and 0 on port B.

Test Plan:
1. Clear high, then release -> pending=0, wb_err=0; reads of R0..R15 return 0 with ready=1.
2. Issue R5 (iss_valid=1, iss_rd=5) -> next cycle pending[5]=1 and rd_ready_a=0 for addr 5. Then write-back wb_addr=5, wb_data=0xDEADBEEF with BYPASS=1 -> same cycle rd_data_a=0xDEADBEEF with ready=1; next cycle pending[5]=0.
3. R0 holds 0x1234, rd_addr_a=0: ba_sel_a=1 -> rd_data_a=0; ba_sel_a=0 -> 0x1234; port B at addr 0 -> 0x1234.
4. R3 pending, issue R3 with no write-back -> iss_ready=0. Issue R3 and write-back R3=0x55 in the same cycle -> iss_ready=1, R3=0x55, pending[3] stays 1.
5. Write-back R7 while not pending -> R7 written and wb_err=1, still 1 after 10 idle cycles. With NUM_REGS=12, write-back to address 13 -> no write and wb_err=1.
6. Issue R2, R9, R14, then assert Clear mid-sequence (asynchronously, between edges) -> pending=0 and all registers 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Imported by the read-port slice and the top level.
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int R0_IDX       = 0;

  // Address width for n registers; never below one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_sb_port.sv
// One combinational read port: R0 zeroing, range check, bypass, ready.
// Instantiated once per read port by regfile_scoreboard.
module regfile_sb_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = addr_w(NUM_REGS),
  parameter int BYPASS   = 1,
  parameter int ZERO_EN  = 0
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              ba_sel,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic [WIDTH-1:0]  reg_data,
  input  logic              reg_pend,
  output logic [WIDTH-1:0]  data,
  output logic              ready
);

  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(NUM_REGS);

  logic zero_hit;
  logic oor;
  logic byp;

  assign zero_hit = (ZERO_EN != 0) && ba_sel &&
                    (addr == ADDR_W'(R0_IDX));
  assign oor      = {1'b0, addr} >= LIMIT;
  assign byp      = (BYPASS != 0) && wb_valid &&
                    (wb_addr == addr);

  // Priority select: zeroing, out of range, bypass, array.
  always_comb begin
    data  = '0;
    ready = 1'b1;
    if (zero_hit || oor) begin
      data  = '0;
      ready = 1'b1;
    end else if (byp) begin
      data  = wb_data;
      ready = 1'b1;
    end else begin
      data  = reg_data;
      ready = !reg_pend;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register bank with two read ports, one write-back port and a
// per-register pending scoreboard for multi-cycle producers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = addr_w(NUM_REGS),
  parameter int BYPASS   = 1,
  parameter int R0_ZERO  = 1
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic                ba_sel_a,
  output logic [WIDTH-1:0]    rd_data_a,
  output logic                rd_ready_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [WIDTH-1:0]    rd_data_b,
  output logic                rd_ready_b,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  output logic                iss_ready,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [WIDTH-1:0]    wb_data,
  output logic [NUM_REGS-1:0] pending,
  output logic                wb_err
);

  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(NUM_REGS);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend_nxt;
  logic                wb_in;
  logic                iss_in;
  logic                wb_hit_iss;
  logic                wb_bad;

  assign wb_in      = {1'b0, wb_addr} < LIMIT;
  assign iss_in     = {1'b0, iss_rd} < LIMIT;
  assign wb_hit_iss = wb_valid && (wb_addr == iss_rd);

  // A pending register accepts a new issue only if it retires now.
  assign iss_ready = iss_in &&
                     (!pending[iss_rd] || wb_hit_iss);

  // Out-of-range or unexpected write-backs flag an error.
  assign wb_bad = wb_valid && (!wb_in || !pending[wb_addr]);

  // Next scoreboard: write-back clears, then issue sets (issue wins).
  always_comb begin
    pend_nxt = pending;
    if (wb_valid && wb_in)
      pend_nxt[wb_addr] = 1'b0;
    if (iss_valid && iss_ready)
      pend_nxt[iss_rd] = 1'b1;
  end

  // Register array, scoreboard and sticky error state.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      pending <= '0;
      wb_err  <= 1'b0;
    end else begin
      if (wb_valid && wb_in)
        regs[wb_addr] <= wb_data;
      pending <= pend_nxt;
      if (wb_bad)
        wb_err <= 1'b1;
    end
  end

  regfile_sb_port #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS),
    .ZERO_EN  (R0_ZERO)
  ) u_port_a (
    .addr     (rd_addr_a),
    .ba_sel   (ba_sel_a),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .reg_data (regs[rd_addr_a]),
    .reg_pend (pending[rd_addr_a]),
    .data     (rd_data_a),
    .ready    (rd_ready_a)
  );

  regfile_sb_port #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS),
    .ZERO_EN  (0)
  ) u_port_b (
    .addr     (rd_addr_b),
    .ba_sel   (1'b0),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .reg_data (regs[rd_addr_b]),
    .reg_pend (pending[rd_addr_b]),
    .data     (rd_data_b),
    .ready    (rd_ready_b)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a 16-register instance
// plus a 12-register instance for the out-of-range write-back case.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        clr;

  logic [3:0]  rd_addr_a, rd_addr_b, iss_rd, wb_addr;
  logic        ba_sel_a, iss_valid, wb_valid;
  logic [31:0] wb_data;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_ready_a, rd_ready_b, iss_ready, wb_err;
  logic [15:0] pending;

  logic [3:0]  c_rd_addr_a, c_rd_addr_b, c_wb_addr;
  logic        c_wb_valid;
  logic [31:0] c_wb_data;
  logic [31:0] c_rd_data_a, c_rd_data_b;
  logic        c_rd_ready_a, c_rd_ready_b;
  logic        c_iss_ready, c_wb_err;
  logic [11:0] c_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .Clock      (clk),
    .Clear      (clr),
    .rd_addr_a  (rd_addr_a),
    .ba_sel_a   (ba_sel_a),
    .rd_data_a  (rd_data_a),
    .rd_ready_a (rd_ready_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .rd_ready_b (rd_ready_b),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .pending    (pending),
    .wb_err     (wb_err)
  );

  regfile_scoreboard #(.NUM_REGS(12)) dut12 (
    .Clock      (clk),
    .Clear      (clr),
    .rd_addr_a  (c_rd_addr_a),
    .ba_sel_a   (1'b0),
    .rd_data_a  (c_rd_data_a),
    .rd_ready_a (c_rd_ready_a),
    .rd_addr_b  (c_rd_addr_b),
    .rd_data_b  (c_rd_data_b),
    .rd_ready_b (c_rd_ready_b),
    .iss_valid  (1'b0),
    .iss_rd     (4'd0),
    .iss_ready  (c_iss_ready),
    .wb_valid   (c_wb_valid),
    .wb_addr    (c_wb_addr),
    .wb_data    (c_wb_data),
    .pending    (c_pending),
    .wb_err     (c_wb_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0; ba_sel_a = 1'b0;
    iss_valid = 1'b0; iss_rd = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    c_rd_addr_a = '0; c_rd_addr_b = '0;
    c_wb_valid = 1'b0; c_wb_addr = '0; c_wb_data = '0;
    tick();
    tick();
    clr = 1'b0;
    tick();

    // 1: reset state
    chk("rst_pending", pending, 16'h0);
    chk("rst_wb_err", wb_err, 1'b0);
    chk("rst_pending12", c_pending, 12'h0);
    chk("rst_wb_err12", c_wb_err, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(i);
      #1;
      chk("rst_rd_a", {rd_ready_a, rd_data_a}, {1'b1, 32'h0});
      chk("rst_rd_b", {rd_ready_b, rd_data_b}, {1'b1, 32'h0});
    end

    // 2: issue R5, then write-back with bypass
    iss_valid = 1'b1; iss_rd = 4'd5;
    #1;
    chk("iss5_ready", iss_ready, 1'b1);
    tick();
    iss_valid = 1'b0;
    rd_addr_a = 4'd5;
    #1;
    chk("iss5_pending", pending, 16'h0020);
    chk("iss5_rd_ready", rd_ready_a, 1'b0);
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF;
    #1;
    chk("byp5_data", rd_data_a, 32'hDEADBEEF);
    chk("byp5_ready", rd_ready_a, 1'b1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("wb5_pending", pending, 16'h0);
    chk("wb5_arr", {rd_ready_a, rd_data_a}, {1'b1, 32'hDEADBEEF});
    chk("wb5_err", wb_err, 1'b0);

    // 3: R0 zeroing on port A only
    iss_valid = 1'b1; iss_rd = 4'd0;
    tick();
    iss_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 32'h1234;
    tick();
    wb_valid = 1'b0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0; ba_sel_a = 1'b1;
    #1;
    chk("r0_zero_a", {rd_ready_a, rd_data_a}, {1'b1, 32'h0});
    chk("r0_b", rd_data_b, 32'h1234);
    ba_sel_a = 1'b0;
    #1;
    chk("r0_a", rd_data_a, 32'h1234);
    chk("r0_err", wb_err, 1'b0);

    // 4: WAW stall, then simultaneous issue + write-back
    iss_valid = 1'b1; iss_rd = 4'd3;
    tick();
    #1;
    chk("waw_pending", pending, 16'h0008);
    chk("waw_stall", iss_ready, 1'b0);
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'h55;
    #1;
    chk("waw_wb_ready", iss_ready, 1'b1);
    tick();
    iss_valid = 1'b0; wb_valid = 1'b0;
    rd_addr_b = 4'd3;
    #1;
    chk("sim_pending", pending, 16'h0008);
    chk("sim_data", {rd_ready_b, rd_data_b}, {1'b0, 32'h55});
    chk("sim_err", wb_err, 1'b0);
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'h56;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("r3_retire", pending, 16'h0);

    // 5: unexpected and out-of-range write-backs
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h77;
    tick();
    wb_valid = 1'b0;
    rd_addr_b = 4'd7;
    #1;
    chk("np_err", wb_err, 1'b1);
    chk("np_data", rd_data_b, 32'h77);
    for (int i = 0; i < 10; i++) tick();
    chk("np_sticky", wb_err, 1'b1);
    chk("oor_err_pre", c_wb_err, 1'b0);
    c_wb_valid = 1'b1; c_wb_addr = 4'd13; c_wb_data = 32'hAA;
    tick();
    c_wb_valid = 1'b0;
    c_rd_addr_a = 4'd13; c_rd_addr_b = 4'd1;
    #1;
    chk("oor_err", c_wb_err, 1'b1);
    chk("oor_rd", {c_rd_ready_a, c_rd_data_a}, {1'b1, 32'h0});
    chk("oor_nowrite", c_rd_data_b, 32'h0);
    chk("oor_pending", c_pending, 12'h0);

    // 6: asynchronous Clear mid-sequence
    iss_valid = 1'b1; iss_rd = 4'd2;
    tick();
    iss_rd = 4'd9;
    tick();
    iss_rd = 4'd14;
    tick();
    iss_valid = 1'b0;
    #1;
    chk("multi_pending", pending, 16'h4204);
    #1;
    clr = 1'b1;
    #1;
    chk("clr_pending", pending, 16'h0);
    chk("clr_err", wb_err, 1'b0);
    chk("clr_err12", c_wb_err, 1'b0);
    rd_addr_a = 4'd5; rd_addr_b = 4'd7;
    #1;
    chk("clr_r5", {rd_ready_a, rd_data_a}, {1'b1, 32'h0});
    chk("clr_r7", {rd_ready_b, rd_data_b}, {1'b1, 32'h0});
    tick();
    clr = 1'b0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd3;
    tick();
    chk("post_r0", rd_data_a, 32'h0);
    chk("post_r3", rd_data_b, 32'h0);
    chk("post_pending", pending, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
